// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic array loader.
// The optional checksum byte is enabled by defining LOADER_SUM_CHECK_EN.
package systolic_pkg;

    localparam int DW    = 8;
    localparam int N_IMG = 16;
    localparam int N_FLT = 9;
    localparam int N_RES = 4;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/systolic_out_serializer.sv
// Captures the four array results and streams them out one byte per handshake.
// With LOADER_SUM_CHECK_EN a fifth byte carries the modulo-2^DW sum of the results.
module systolic_out_serializer
    import systolic_pkg::*;
#(
    parameter int DW = systolic_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              active,
    input  logic [N_RES*DW-1:0] arr_o,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic              done
);

`ifdef LOADER_SUM_CHECK_EN
    localparam int N_OUT = N_RES + 1;
    logic [DW-1:0] sum;
`else
    localparam int N_OUT = N_RES;
`endif

    logic [DW-1:0] res [N_RES];
    logic [2:0]    idx;

    // A byte moves on only when the sink takes it; done marks the final byte.
    assign out_valid = active;
    assign done      = active && out_ready && (idx == 3'(N_OUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_RES; k++) res[k] <= '0;
            idx <= '0;
        end else begin
            if (capture) begin
                for (int k = 0; k < N_RES; k++) res[k] <= arr_o[(N_RES-1-k)*DW +: DW];
            end
            if (done) begin
                idx <= '0;
            end else if (active && out_ready) begin
                idx <= idx + 3'd1;
            end
        end
    end

`ifdef LOADER_SUM_CHECK_EN
    always_comb begin
        sum = res[0] + res[1] + res[2] + res[3];
    end
`endif

    always_comb begin
        out_data = '0;
        case (idx)
            3'd0: out_data = res[0];
            3'd1: out_data = res[1];
            3'd2: out_data = res[2];
            3'd3: out_data = res[3];
`ifdef LOADER_SUM_CHECK_EN
            3'd4: out_data = sum;
`endif
            default: out_data = '0;
        endcase
    end

endmodule

// File: rtl/systolic_loader.sv
// Loads a 4x4 image and 3x3 filter byte-serially, runs the array, then drains results.
// Optional checksum byte after the results: define LOADER_SUM_CHECK_EN.
module systolic_loader
    import systolic_pkg::*;
#(
    parameter int DW      = systolic_pkg::DW,
    parameter int LATENCY = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    output logic                in_ready,
    output logic [N_IMG*DW-1:0] arr_i,
    output logic [N_FLT*DW-1:0] arr_f,
    output logic                arr_rst,
    input  logic [N_RES*DW-1:0] arr_o,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    input  logic                out_ready,
    output logic                busy
);

    // Handshake rule: a byte transfers on a clock edge where valid and ready are both high.
    state_t        state, state_nxt;
    logic [4:0]    byte_cnt;
    logic [7:0]    cyc_cnt;
    logic [4:0]    flt_idx;
    logic [DW-1:0] img [N_IMG];
    logic [DW-1:0] flt [N_FLT];
    logic          accept, last_byte, run_end, drain_done;

    assign in_ready  = (state == ST_LOAD);
    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt == 5'(N_IMG + N_FLT - 1));
    assign run_end   = (state == ST_RUN) && (cyc_cnt == 8'(LATENCY - 1));
    assign flt_idx   = byte_cnt - 5'(N_IMG);
    assign arr_rst   = (state != ST_RUN);
    assign busy      = (state != ST_LOAD) || (byte_cnt != 5'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (accept && last_byte) state_nxt = ST_RUN;
            ST_RUN:   if (run_end)             state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_done)          state_nxt = ST_LOAD;
            default:                           state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            cyc_cnt  <= '0;
            for (int k = 0; k < N_IMG; k++) img[k] <= '0;
            for (int k = 0; k < N_FLT; k++) flt[k] <= '0;
        end else begin
            if (accept) begin
                byte_cnt <= last_byte ? 5'd0 : byte_cnt + 5'd1;
                if (byte_cnt < 5'(N_IMG)) begin
                    img[byte_cnt[3:0]] <= in_data;
                end else begin
                    flt[flt_idx[3:0]] <= in_data;
                end
            end
            if (state == ST_RUN && !run_end) begin
                cyc_cnt <= cyc_cnt + 8'd1;
            end else begin
                cyc_cnt <= '0;
            end
        end
    end

    // Element 0 of each matrix sits in the MSBs of the flattened bus.
    always_comb begin
        arr_i = '0;
        arr_f = '0;
        for (int k = 0; k < N_IMG; k++) arr_i[(N_IMG-1-k)*DW +: DW] = img[k];
        for (int k = 0; k < N_FLT; k++) arr_f[(N_FLT-1-k)*DW +: DW] = flt[k];
    end

    systolic_out_serializer #(.DW(DW)) u_ser (
        .clk       (clk),
        .rst       (rst),
        .capture   (run_end),
        .active    (state == ST_DRAIN),
        .arr_o     (arr_o),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (drain_done)
    );

endmodule

// File: doc/systolic_loader.md
SYSTOLIC_LOADER -- requirements
Module: systolic_loader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameters (name, default, meaning) SHALL be:
- DW, 8, element width.
- LATENCY, 12, array run cycles before result capture; legal range 1..255.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- rst, in, 1, async active-low reset.
- in_valid, in, 1, input byte valid.
- in_data, in, DW, input byte.
- in_ready, out, 1, loader accepts input.
- arr_i, out, 16*DW, image i00..i33, i00 in MSBs, row-major.
- arr_f, out, 9*DW, filter f00..f22, f00 in MSBs.
- arr_rst, out, 1, array reset, active-high.
- arr_o, in, 4*DW, results o00, o01, o10, o11, o00 in MSBs.
- out_valid, out, 1, result byte valid.
- out_data, out, DW, result byte.
- out_ready, in, 1, sink accepts result.
- busy, out, 1, frame in progress.

Function
REQ-004 The FSM SHALL have three states: LOAD, RUN, DRAIN.
REQ-005 LOAD behaviour:
- in_ready=1.
- A byte is accepted on in_valid&&in_ready.
- Bytes 0..15 fill i00..i33 row-major; bytes 16..24 fill f00..f22 row-major.
REQ-006 Acceptance of byte 24 SHALL move the FSM to RUN on the next edge; the byte counter returns to 0.
REQ-007 RUN behaviour:
- arr_rst=0 for exactly LATENCY cycles.
- The cycle counter starts at 0.
- In the cycle where the counter equals LATENCY-1, arr_o is captured into the result registers, and on the following edge arr_rst=1 and the FSM enters DRAIN.
REQ-008 DRAIN behaviour:
- out_valid=1.
- out_data presents o00, o01, o10, o11 in order.
- A byte advances only on out_valid&&out_ready; out_data stays stable while stalled.
REQ-009 Acceptance of the last DRAIN byte SHALL return the FSM to LOAD on the next edge, with a zero-bubble re-entry: in_ready=1 in that cycle.
REQ-010 Outside LOAD, in_ready SHALL be 0; in_valid is ignored and the data is not consumed.
REQ-011 arr_i and arr_f SHALL be registered and SHALL stay constant from the end of LOAD until the next frame's first accepted byte.
REQ-012 arr_rst SHALL be 1 in LOAD and DRAIN.
REQ-013 busy SHALL be 1 in RUN or DRAIN, or in LOAD with a nonzero byte count.
REQ-014 No arithmetic is performed on data; only the counters increment (byte counter 5 bits, cycle counter 8 bits, drain index 3 bits).

Reset
REQ-015 rst low SHALL asynchronously force:
- state=LOAD and all counters 0;
- arr_i, arr_f and the result registers 0;
- arr_rst=1, out_valid=0, out_data=0, busy=0.
REQ-016 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-017 A reset in any state SHALL discard the partial frame and any results not yet drained; the next frame starts at byte 0.

Configuration
REQ-018 With macro LOADER_SUM_CHECK_EN defined, DRAIN SHALL emit a fifth byte after o11: (o00+o01+o10+o11) mod 2^DW.
REQ-019 Without LOADER_SUM_CHECK_EN, DRAIN SHALL emit exactly four bytes and the checksum logic SHALL be absent.

Structure
REQ-020 Shared package systolic_pkg SHALL hold:
- DW;
- image, filter and result element counts (16, 9, 4);
- the LOAD/RUN/DRAIN state encoding.
REQ-021 The result registers, drain index and optional checksum SHALL live in a single sub-module, systolic_out_serializer.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Basic frame: stream image 8,3,9,1,7,7,2,8,5,6,3,1,4,9,2,6 then filter 1,5,8,6,0,7,3,1,2, with an array model returning 178,177,134,165 -> out bytes 178,177,134,165, and arr_rst low for exactly 12 cycles.
- Checksum: same frame with LOADER_SUM_CHECK_EN -> a fifth byte of 142.
- Backpressure: out_ready toggles 1/0 each cycle -> each byte is held stable while stalled, with no loss or duplication.
- Input gaps: in_valid=0 on random cycles during LOAD -> identical arr_i/arr_f and results; in_ready=0 throughout RUN and DRAIN even with in_valid=1.
- Mid-frame reset: rst low after byte 10, then a full frame -> arr_i matches only the second frame, and the first frame's outputs are never emitted.
- Back-to-back frames: a second frame presented in the cycle after the last drain -> accepted immediately, and both result sets are emitted in order.
